// File: rtl/pipeline_issue_collect.sv
// rtl/pipeline_issue_collect.sv - host-side issue/collect driver for a fixed-latency execute pipeline
//
// Operand pairs are buffered in an input FIFO, packed as {op_a, op_b}, and issued
// at most one per cycle. A tag shift register matched to the pipeline latency marks
// which result_in cycles carry real results; those are captured into a result FIFO.
// Issue is gated by a credit check so a captured result always has a free slot.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   op_valid   operand pair valid            op_ready  input FIFO can accept
//   op_a/op_b  upper/lower operand
//   instr_out  registered instruction word   issue_out instr_out is real (0 = bubble)
//   result_in  pipeline result word
//   res_valid  result FIFO not empty          res_ready consumer accepts head
//   res_data   head of the result FIFO (0 when empty)
//   busy       work queued, in flight, or waiting in the result FIFO
module pipeline_issue_collect #(
    parameter int OP_W      = 16,
    parameter int LATENCY   = 2,
    parameter int IN_DEPTH  = 4,
    parameter int RES_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [OP_W-1:0]   op_a,
    input  logic [OP_W-1:0]   op_b,
    output logic [2*OP_W-1:0] instr_out,
    output logic              issue_out,
    input  logic [2*OP_W-1:0] result_in,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [2*OP_W-1:0] res_data,
    output logic              busy
);

    localparam int W      = 2 * OP_W;
    localparam int IN_AW  = $clog2(IN_DEPTH);
    localparam int RES_AW = $clog2(RES_DEPTH);
    localparam int CW     = $clog2(RES_DEPTH + 1);
    localparam int SW     = CW + 1;

    localparam logic [IN_AW:0]  IN_ONE  = 1;
    localparam logic [RES_AW:0] RES_ONE = 1;
    localparam logic [CW-1:0]   CR_ONE  = 1;

    // op_ready is held low until the first edge after reset releases.
    logic ready_en;

    // Input FIFO
    logic [W-1:0]   in_mem [IN_DEPTH];
    logic [IN_AW:0] in_wptr, in_rptr;
    logic           in_empty, in_full, in_push;

    // Result FIFO
    logic [W-1:0]    res_mem [RES_DEPTH];
    logic [RES_AW:0] res_wptr, res_rptr, res_count;
    logic            res_empty, res_pop;

    // Issue / capture tracking
    logic [LATENCY-1:0] tag;
    logic [CW-1:0]      inflight;
    logic               issue, capture;

    assign in_empty = (in_wptr == in_rptr);
    assign in_full  = (in_wptr[IN_AW] != in_rptr[IN_AW]) &&
                      (in_wptr[IN_AW-1:0] == in_rptr[IN_AW-1:0]);
    assign op_ready = ready_en && !in_full;
    assign in_push  = op_valid && op_ready;

    assign res_empty = (res_wptr == res_rptr);
    assign res_count = res_wptr - res_rptr;
    assign res_valid = !res_empty;
    assign res_pop   = res_valid && res_ready;
    assign res_data  = res_valid ? res_mem[res_rptr[RES_AW-1:0]] : '0;

    // Credit check: every issued instruction reserves a result slot until it is
    // captured, so the result FIFO can never overflow even with res_ready low.
    assign issue   = !in_empty && ((SW'(res_count) + SW'(inflight)) < SW'(RES_DEPTH));
    assign capture = tag[LATENCY-1];

    assign busy = !in_empty || (inflight != '0) || !res_empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    // Input FIFO pointers; storage needs no reset since it is only read when non-empty.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_wptr <= '0;
            in_rptr <= '0;
        end else begin
            if (in_push) in_wptr <= in_wptr + IN_ONE;
            if (issue)   in_rptr <= in_rptr + IN_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (in_push) in_mem[in_wptr[IN_AW-1:0]] <= {op_a, op_b};
    end

    // Issue register: a bubble drives an all-zero word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_out <= '0;
            issue_out <= 1'b0;
        end else if (issue) begin
            instr_out <= in_mem[in_rptr[IN_AW-1:0]];
            issue_out <= 1'b1;
        end else begin
            instr_out <= '0;
            issue_out <= 1'b0;
        end
    end

    // issue_out is stage 0 of the in-flight marker; the tag register supplies the
    // remaining LATENCY stages so its MSB lines up with the matching result_in.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag <= '0;
        end else begin
            tag <= LATENCY'({tag, issue_out});
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            inflight <= '0;
        end else begin
            case ({issue, capture})
                2'b10:   inflight <= inflight + CR_ONE;
                2'b01:   inflight <= inflight - CR_ONE;
                default: inflight <= inflight;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            res_wptr <= '0;
            res_rptr <= '0;
        end else begin
            if (capture) res_wptr <= res_wptr + RES_ONE;
            if (res_pop) res_rptr <= res_rptr + RES_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (capture) res_mem[res_wptr[RES_AW-1:0]] <= result_in;
    end

endmodule

// File: tb/tb_pipeline_issue_collect.sv
// tb/tb_pipeline_issue_collect.sv - self-checking bench for pipeline_issue_collect
module tb_pipeline_issue_collect;

    localparam int LAT = 2;
    localparam int IND = 4;
    localparam int RSD = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [15:0] op_a = '0;
    logic [15:0] op_b = '0;
    logic [31:0] instr_out;
    logic        issue_out;
    logic [31:0] result_in;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [31:0] res_data;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pipeline_issue_collect #(
        .OP_W(16), .LATENCY(LAT), .IN_DEPTH(IND), .RES_DEPTH(RSD)
    ) dut (
        .clk(clk), .reset(rst_n),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .instr_out(instr_out), .issue_out(issue_out), .result_in(result_in),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .busy(busy)
    );

    function automatic logic [31:0] psum(input logic [31:0] d);
        logic [15:0] s;
        s = d[31:16] + d[15:0];
        return {16'h0000, s};
    endfunction

    // Pipeline stub: result word is the 16-bit sum of the instruction seen LAT cycles earlier.
    logic [31:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= instr_out;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign result_in = psum(pipe[LAT-1]);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h, want %h", name, $time, act, exp);
        end
    endtask

    // Transaction-level model: queues of pending operands, in-flight results with
    // the edge at which each must land, and buffered results.
    typedef struct {
        logic [31:0] d;
        int          due;
    } fl_t;

    logic [31:0] m_in_q [$];
    fl_t         m_fl [$];
    logic [31:0] m_res_q [$];
    logic [31:0] m_instr = '0;
    logic        m_issue = 1'b0;
    logic        m_ready_en = 1'b0;
    int          m_edge = 0;
    bit          m_push, m_iss, m_pop, m_cap;
    logic [31:0] m_capd, m_hd;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_in_q.delete();
                m_fl.delete();
                m_res_q.delete();
                m_instr = '0;
                m_issue = 1'b0;
                m_ready_en = 1'b0;
            end else begin
                m_edge++;
                m_push = op_valid && m_ready_en && (m_in_q.size() < IND);
                m_iss  = (m_in_q.size() > 0) && ((m_res_q.size() + m_fl.size()) < RSD);
                m_pop  = (m_res_q.size() > 0) && res_ready;
                m_cap  = 1'b0;
                if (m_fl.size() > 0 && m_fl[0].due == m_edge) begin
                    m_cap  = 1'b1;
                    m_capd = m_fl[0].d;
                    void'(m_fl.pop_front());
                end
                if (m_pop) void'(m_res_q.pop_front());
                if (m_cap) m_res_q.push_back(m_capd);
                if (m_iss) begin
                    m_hd = m_in_q.pop_front();
                    m_instr = m_hd;
                    m_issue = 1'b1;
                    m_fl.push_back('{d: psum(m_hd), due: m_edge + 1 + LAT});
                end else begin
                    m_instr = '0;
                    m_issue = 1'b0;
                end
                if (m_push) m_in_q.push_back({op_a, op_b});
                m_ready_en = 1'b1;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            chk("op_ready", 32'(op_ready), 32'(m_ready_en && (m_in_q.size() < IND)));
            chk("issue_out", 32'(issue_out), 32'(m_issue));
            chk("instr_out", instr_out, m_instr);
            chk("res_valid", 32'(res_valid), 32'(m_res_q.size() > 0));
            if (res_valid && m_res_q.size() > 0) chk("res_data", res_data, m_res_q[0]);
            chk("busy", 32'(busy),
                32'((m_in_q.size() > 0) || (m_fl.size() > 0) || (m_res_q.size() > 0)));
        end
    end

    // Log of consumed results and issue cycles for the directed checks.
    logic [31:0] popped [$];
    int          iss_cyc [$];
    int          ncyc = 0;
    initial begin
        forever begin
            @(negedge clk);
            ncyc++;
            if (res_valid === 1'b1 && res_ready === 1'b1) popped.push_back(res_data);
            if (issue_out === 1'b1) iss_cyc.push_back(ncyc);
        end
    end

    task automatic push(input logic [15:0] a, input logic [15:0] b);
        bit acc;
        bit done;
        done = 1'b0;
        op_valid = 1'b1;
        op_a = a;
        op_b = b;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            acc = op_ready;
            @(posedge clk);
            #2;
            if (acc) done = 1'b1;
        end
        op_valid = 1'b0;
        chk("push_accept", 32'(done), 32'd1);
    endtask

    task automatic wait_idle(input int n);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < n && !ok; i++) begin
            @(negedge clk);
            if (!busy) ok = 1'b1;
            else begin
                @(posedge clk);
                #2;
            end
        end
        chk("drain_done", 32'(ok), 32'd1);
        @(posedge clk);
        #2;
    endtask

    logic [15:0] s2_a [4] = '{16'd1, 16'd2, 16'd4, 16'd3};
    logic [15:0] s2_b [4] = '{16'd2, 16'd3, 16'd4, 16'd4};
    logic [31:0] s2_e [4] = '{32'd3, 32'd5, 32'd8, 32'd7};
    logic [15:0] w_a [6] = '{16'hFFFF, 16'h0001, 16'h1234, 16'h0010, 16'h8000, 16'h00AA};
    logic [15:0] w_b [6] = '{16'h0001, 16'h00FF, 16'h1111, 16'h0020, 16'h8000, 16'h0055};
    logic [31:0] w_e [6] = '{32'h0000_0000, 32'h0000_0100, 32'h0000_2345,
                             32'h0000_0030, 32'h0000_0000, 32'h0000_00FF};

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_instr", instr_out, 32'h0);
        chk("rst_issue", 32'(issue_out), 32'd0);
        chk("rst_op_ready", 32'(op_ready), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_data", res_data, 32'h0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_before_edge", 32'(op_ready), 32'd0);
        @(posedge clk);
        #2;
        @(negedge clk);
        chk("ready_after_edge", 32'(op_ready), 32'd1);
        @(posedge clk);
        #2;

        // Single transaction latency
        push(16'h0001, 16'h0002);
        @(negedge clk);
        chk("s1_no_issue_yet", 32'(issue_out), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("s1_issue", 32'(issue_out), 32'd1);
        chk("s1_instr", instr_out, 32'h0001_0002);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("s1_res_not_yet", 32'(res_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("s1_res_valid", 32'(res_valid), 32'd1);
        chk("s1_res_data", res_data, 32'h0000_0003);
        chk("s1_busy_held", 32'(busy), 32'd1);
        @(posedge clk);
        #2;
        res_ready = 1'b1;
        @(posedge clk);
        #2;
        res_ready = 1'b0;
        @(negedge clk);
        chk("s1_busy_fall", 32'(busy), 32'd0);
        chk("s1_res_empty", 32'(res_valid), 32'd0);
        @(posedge clk);
        #2;

        // Back-to-back stream with consumer always ready
        popped.delete();
        iss_cyc.delete();
        res_ready = 1'b1;
        for (int i = 0; i < 4; i++) push(s2_a[i], s2_b[i]);
        wait_idle(50);
        chk("s2_count", 32'(popped.size()), 32'd4);
        for (int i = 0; i < 4 && i < popped.size(); i++) chk("s2_data", popped[i], s2_e[i]);
        chk("s2_issues", 32'(iss_cyc.size()), 32'd4);
        if (iss_cyc.size() == 4) chk("s2_back_to_back", 32'(iss_cyc[3] - iss_cyc[0]), 32'd3);

        // Consumer stalled: credits cap issue, input FIFO fills
        popped.delete();
        iss_cyc.delete();
        res_ready = 1'b0;
        for (int i = 0; i < 8; i++) push(16'(i + 1), 16'(10 * (i + 1)));
        repeat (10) @(posedge clk);
        #2;
        @(negedge clk);
        chk("s3_issue_cap", 32'(iss_cyc.size()), 32'd4);
        chk("s3_full_ready", 32'(op_ready), 32'd0);
        chk("s3_res_valid", 32'(res_valid), 32'd1);
        @(posedge clk);
        #2;
        // Release the consumer while pushing into the full input FIFO
        res_ready = 1'b1;
        op_valid = 1'b1;
        op_a = 16'd9;
        op_b = 16'd90;
        @(negedge clk);
        chk("s3_full_same_cycle", 32'(op_ready), 32'd0);
        for (int i = 8; i < 12; i++) push(16'(i + 1), 16'(10 * (i + 1)));
        wait_idle(200);
        chk("s3_count", 32'(popped.size()), 32'd12);
        for (int i = 0; i < 12 && i < popped.size(); i++) chk("s3_order", popped[i], 32'(11 * (i + 1)));

        // Pointer wrap over three rounds
        popped.delete();
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 6; i++) push(w_a[i], w_b[i]);
            wait_idle(100);
        end
        chk("wrap_count", 32'(popped.size()), 32'd18);
        for (int i = 0; i < 18 && i < popped.size(); i++) chk("wrap_data", popped[i], w_e[i % 6]);

        // Asynchronous reset with work in flight
        popped.delete();
        res_ready = 1'b0;
        push(16'h0005, 16'h0006);
        push(16'h0007, 16'h0008);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_instr", instr_out, 32'h0);
        chk("arst_issue", 32'(issue_out), 32'd0);
        chk("arst_op_ready", 32'(op_ready), 32'd0);
        chk("arst_res_valid", 32'(res_valid), 32'd0);
        chk("arst_res_data", res_data, 32'h0);
        chk("arst_busy", 32'(busy), 32'd0);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst_ready_low", 32'(op_ready), 32'd0);
        res_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("arst_no_capture", 32'(res_valid), 32'd0);
        end
        chk("arst_ready_up", 32'(op_ready), 32'd1);
        chk("arst_nothing_popped", 32'(popped.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
